// File: rtl/cart_loader.sv
// cart_loader: bus initiator that copies a byte stream into cartridge PRG or
// CHR memory before the CPU/PPU run. A start pulse latches one transfer:
// target (0=PRG, 1=CHR), start address and byte count. Each stream byte is
// written to the next sequential address. PRG addresses wrap at 0x7FFF and
// CHR addresses wrap at 0x1FFF. CHR bit 13 is never driven high.
//
// Optional build macro: CART_LOADER_VERIFY_EN.
//   When it is defined, each write is followed by a read-back and a compare.
//   A mismatch raises err_out, which stays set until the next accepted start.
//   When it is undefined, err_out is tied 0 and the read-data inputs are unused.
//
// Ports:
//   clk_in, rst_n_in         clock, asynchronous active-low reset
//   start_in, tgt_in,        transfer request (start is ignored while busy)
//   addr_in, len_in
//   d_in, d_valid_in,        byte stream with ready/valid handshake
//   d_rdy_out
//   busy_out, done_out,      status (the loader owns the cart buses while busy)
//   err_out
//   prg_*                    PRG memory bus (nce active-low, r_nw 0=write)
//   chr_*                    CHR memory bus (r_nw 0=write)
module cart_loader #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 tgt_in,
  input  logic [14:0]          addr_in,
  input  logic [LEN_WIDTH-1:0] len_in,
  input  logic [7:0]           d_in,
  input  logic                 d_valid_in,
  output logic                 d_rdy_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 err_out,
  output logic                 prg_nce_out,
  output logic [14:0]          prg_a_out,
  output logic                 prg_r_nw_out,
  output logic [7:0]           prg_d_out,
  input  logic [7:0]           prg_d_in,
  output logic [13:0]          chr_a_out,
  output logic                 chr_r_nw_out,
  output logic [7:0]           chr_d_out,
  input  logic [7:0]           chr_d_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_VRD   = 3'd3,
    S_VCMP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_tgt;
  logic [14:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [7:0]           r_data;
  logic                 w_last;
  logic                 w_step;
  logic                 w_start;
  logic [14:0]          w_addr_inc;

  assign w_start = (r_state == S_IDLE) && start_in;
  assign w_last  = (r_rem == LEN_WIDTH'(1));

  // CHR keeps only 13 address bits, so its increment wraps at 0x1FFF.
  assign w_addr_inc = r_tgt ? {2'b00, r_addr[12:0] + 13'd1} : (r_addr + 15'd1);

`ifdef CART_LOADER_VERIFY_EN
  logic       r_err;
  logic [7:0] w_rd_data;
  // The address advances only after the read-back compare.
  assign w_step    = (r_state == S_VCMP);
  assign w_rd_data = r_tgt ? chr_d_in : prg_d_in;
  assign err_out   = r_err;

  // Sticky mismatch flag, cleared by an accepted start.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if ((r_state == S_VCMP) && (w_rd_data != r_data)) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_step   = (r_state == S_WRITE);
  assign err_out  = 1'b0;
  assign w_unused = ^{prg_d_in, chr_d_in};
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_next = (len_in == '0) ? S_DONE : S_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (d_valid_in) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_WAIT;
        end
      end
`ifdef CART_LOADER_VERIFY_EN
      S_WRITE: w_next = S_VRD;
      S_VRD:   w_next = S_VCMP;
      S_VCMP:  w_next = w_last ? S_DONE : S_WAIT;
`else
      S_WRITE: w_next = w_last ? S_DONE : S_WAIT;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer registers: latched on start, stepped after each byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tgt  <= 1'b0;
      r_addr <= 15'd0;
      r_rem  <= '0;
      r_data <= 8'd0;
    end else begin
      if (w_start) begin
        r_tgt  <= tgt_in;
        r_addr <= addr_in;
        r_rem  <= len_in;
      end else if (w_step) begin
        r_addr <= w_addr_inc;
        r_rem  <= r_rem - LEN_WIDTH'(1);
      end
      if ((r_state == S_WAIT) && d_valid_in) begin
        r_data <= d_in;
      end
    end
  end

  // Bus and status outputs decoded from the state register.
  always_comb begin
    d_rdy_out    = 1'b0;
    busy_out     = 1'b0;
    done_out     = 1'b0;
    prg_nce_out  = 1'b1;
    prg_a_out    = 15'd0;
    prg_r_nw_out = 1'b1;
    prg_d_out    = 8'd0;
    chr_a_out    = 14'd0;
    chr_r_nw_out = 1'b1;
    chr_d_out    = 8'd0;
    case (r_state)
      S_WAIT: begin
        d_rdy_out = 1'b1;
        busy_out  = 1'b1;
      end
      S_WRITE: begin
        busy_out = 1'b1;
        if (r_tgt) begin
          chr_r_nw_out = 1'b0;
          chr_a_out    = {1'b0, r_addr[12:0]};
          chr_d_out    = r_data;
        end else begin
          prg_nce_out  = 1'b0;
          prg_r_nw_out = 1'b0;
          prg_a_out    = r_addr;
          prg_d_out    = r_data;
        end
      end
`ifdef CART_LOADER_VERIFY_EN
      S_VRD, S_VCMP: begin
        busy_out = 1'b1;
        if (r_tgt) begin
          chr_a_out = {1'b0, r_addr[12:0]};
        end else begin
          prg_nce_out = 1'b0;
          prg_a_out   = r_addr;
        end
      end
`endif
      S_DONE:  done_out = 1'b1;
      default: done_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cart_loader.sv
module tb_cart_loader;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in, tgt_in, d_valid_in;
  logic [14:0] addr_in;
  logic [15:0] len_in;
  logic [7:0]  d_in;
  logic        d_rdy_out, busy_out, done_out, err_out;
  logic        prg_nce_out, prg_r_nw_out, chr_r_nw_out;
  logic [14:0] prg_a_out;
  logic [13:0] chr_a_out;
  logic [7:0]  prg_d_out, chr_d_out, prg_d_in, chr_d_in;

  cart_loader #(.LEN_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .tgt_in(tgt_in),
    .addr_in(addr_in), .len_in(len_in), .d_in(d_in), .d_valid_in(d_valid_in),
    .d_rdy_out(d_rdy_out), .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .prg_nce_out(prg_nce_out), .prg_a_out(prg_a_out), .prg_r_nw_out(prg_r_nw_out),
    .prg_d_out(prg_d_out), .prg_d_in(prg_d_in), .chr_a_out(chr_a_out),
    .chr_r_nw_out(chr_r_nw_out), .chr_d_out(chr_d_out), .chr_d_in(chr_d_in)
  );

  always #5 clk_in = ~clk_in;

`ifdef CART_LOADER_VERIFY_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic        tgt;
    logic [14:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;
  wr_t wq[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  logic mon_wp, mon_wc;

  // Synchronous memory models used for read-back.
  logic [7:0]  prg_mem [0:32767];
  logic [7:0]  chr_mem [0:8191];
  logic        corrupt_en = 1'b0;
  logic [14:0] corrupt_a  = 15'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!prg_nce_out && !prg_r_nw_out) prg_mem[prg_a_out] <= prg_d_out;
    if (!chr_r_nw_out) chr_mem[chr_a_out[12:0]] <= chr_d_out;
    prg_d_in <= prg_mem[prg_a_out] ^ ((corrupt_en && prg_a_out == corrupt_a) ? 8'h01 : 8'h00);
    chr_d_in <= chr_mem[chr_a_out[12:0]];
  end

  // Bus monitor: records every write strobe and checks per-write invariants.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      mon_wp = !prg_nce_out && !prg_r_nw_out;
      mon_wc = !chr_r_nw_out;
      if (mon_wp || mon_wc) begin
        check("rdy_low_in_write", {31'd0, d_rdy_out}, 32'd0);
        check("single_strobe", {31'd0, mon_wp && mon_wc}, 32'd0);
        if (mon_wc) begin
          check("chr_a13_zero", {31'd0, chr_a_out[13]}, 32'd0);
          check("prg_nce_on_chr", {31'd0, prg_nce_out}, 32'd1);
          wq.push_back('{1'b1, {1'b0, chr_a_out}, chr_d_out, cyc});
        end else begin
          wq.push_back('{1'b0, prg_a_out, prg_d_out, cyc});
        end
      end
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err_out;
      end
    end
  end

  // Runs one transfer from the posedge+1 phase and compares the observed writes
  // against sequential addresses computed by modular arithmetic.
  // vmode: 0 continuous valid, 1 valid toggling every 3 cycles, 2 random valid.
  task automatic run_transfer(input logic tgt, input logic [14:0] addr, input int len,
                              input int vmode, input bit fixed, input bit inj,
                              input logic exp_err);
    logic [7:0] bytes[$];
    int idx, budget, k, start_cyc, ea;
    bit acc, injected;
    bytes.delete();
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom_range(0, 255)));
    if (fixed) begin
      bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hFF;
    end
    wq.delete();
    done_cnt = 0;
    start_in = 1'b1; tgt_in = tgt; addr_in = addr; len_in = 16'(len);
    start_cyc = cyc;
    idx = 0; k = 0; injected = 0;
    d_in = (len > 0) ? bytes[0] : 8'h00;
    d_valid_in = (len > 0) && (vmode != 2 || $urandom_range(0, 1) == 1);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("err_clear_on_start", {31'd0, err_out}, 32'd0);
    budget = 30 * len + 20;
    while (idx < len && budget > 0) begin
      @(negedge clk_in);
      acc = d_valid_in && d_rdy_out;
      @(posedge clk_in); #1;
      budget--; k++;
      if (acc) idx++;
      d_in = (idx < len) ? bytes[idx] : 8'h00;
      case (vmode)
        0:       d_valid_in = (idx < len);
        1:       d_valid_in = (idx < len) && ((k / 3) % 2 == 0);
        default: d_valid_in = (idx < len) && ($urandom_range(0, 1) == 1);
      endcase
      if (inj && idx == 2 && !injected) begin
        start_in = 1'b1; tgt_in = ~tgt; addr_in = 15'h2222; len_in = 16'd2;
        injected = 1;
      end else begin
        start_in = 1'b0;
      end
    end
    start_in = 1'b0;
    d_valid_in = 1'b0;
    check("stream_complete", idx, len);
    for (int w = 0; w < 20 && done_cnt == 0; w++) @(negedge clk_in);
    @(negedge clk_in);
    check("done_pulses", done_cnt, 1);
    check("err_at_done", {31'd0, done_err}, {31'd0, exp_err});
    check("err_held", {31'd0, err_out}, {31'd0, exp_err});
    check("busy_after", {31'd0, busy_out}, 32'd0);
    check("rdy_after", {31'd0, d_rdy_out}, 32'd0);
    check("write_count", wq.size(), len);
    if (len == 0) check("zero_len_done_fast", {31'd0, (done_cyc - start_cyc) <= 2}, 32'd1);
    for (int i = 0; i < len && i < wq.size(); i++) begin
      ea = tgt ? ((int'(addr) % 8192 + i) % 8192) : ((int'(addr) + i) % 32768);
      check("wr_tgt", {31'd0, wq[i].tgt}, {31'd0, tgt});
      check("wr_addr", {17'd0, wq[i].a}, ea);
      check("wr_data", {24'd0, wq[i].d}, {24'd0, bytes[i]});
      if (vmode == 0 && i > 0) check("wr_spacing", wq[i].cyc - wq[i-1].cyc, GAP);
    end
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    logic        tgt;
    logic [14:0] addr;
    int          len;
    int          vmode;
    bit          fixed;
    bit          inj;
    logic [14:0] exp_last;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 15'h4000, 3, 0, 1'b1, 1'b0, 15'h4002};  // PRG load A5,5A,FF
    vecs[1] = '{1'b1, 15'h1FFE, 4, 0, 1'b0, 1'b0, 15'h0001};  // CHR wrap
    vecs[2] = '{1'b0, 15'h7FFE, 5, 1, 1'b0, 1'b0, 15'h0002};  // backpressure + PRG wrap
    vecs[3] = '{1'b0, 15'h1234, 0, 0, 1'b0, 1'b0, 15'h0000};  // zero length
    vecs[4] = '{1'b0, 15'h0100, 4, 0, 1'b0, 1'b1, 15'h0103};  // start while busy
    vecs[5] = '{1'b1, 15'h3FFF, 2, 2, 1'b0, 1'b0, 15'h0000};  // CHR ignores addr[14:13]

    rst_n_in = 1'b0; start_in = 1'b0; tgt_in = 1'b0; addr_in = 15'd0;
    len_in = 16'd0; d_in = 8'd0; d_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_rdy", {31'd0, d_rdy_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_err", {31'd0, err_out}, 32'd0);
    check("rst_prg_nce", {31'd0, prg_nce_out}, 32'd1);
    check("rst_prg_rnw", {31'd0, prg_r_nw_out}, 32'd1);
    check("rst_chr_rnw", {31'd0, chr_r_nw_out}, 32'd1);
    check("rst_buses", {1'b0, prg_a_out, chr_a_out, 2'b00} | {16'd0, prg_d_out, chr_d_out}, 32'd0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    for (int v = 0; v < 6; v++) begin
      run_transfer(vecs[v].tgt, vecs[v].addr, vecs[v].len, vecs[v].vmode,
                   vecs[v].fixed, vecs[v].inj, 1'b0);
      if (vecs[v].len > 0 && wq.size() > 0)
        check("last_addr", {17'd0, wq[wq.size()-1].a}, {17'd0, vecs[v].exp_last});
    end

    // Reset after the second write of an 8-byte transfer.
    wq.delete(); done_cnt = 0;
    start_in = 1'b1; tgt_in = 1'b0; addr_in = 15'h0500; len_in = 16'd8;
    @(posedge clk_in); #1;
    start_in = 1'b0; d_in = 8'h3C; d_valid_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (wq.size() >= 2) break;
    end
    rst_n_in = 1'b0;
    #1;
    check("midrst_writes", wq.size(), 2);
    if (wq.size() >= 2) begin
      check("midrst_a0", {17'd0, wq[0].a}, 32'h0500);
      check("midrst_a1", {17'd0, wq[1].a}, 32'h0501);
      check("midrst_d1", {24'd0, wq[1].d}, 32'h3C);
    end
    check("midrst_nce", {31'd0, prg_nce_out}, 32'd1);
    check("midrst_rnw", {31'd0, prg_r_nw_out}, 32'd1);
    check("midrst_busy", {31'd0, busy_out}, 32'd0);
    check("midrst_rdy", {31'd0, d_rdy_out}, 32'd0);
    d_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("midrst_no_done", done_cnt, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    run_transfer(1'b1, 15'h0010, 2, 0, 1'b0, 1'b0, 1'b0);

    // Randomized transfers against the address/data model.
    for (int r = 0; r < 12; r++) begin
      run_transfer(1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)),
                   $urandom_range(1, 6), 2, 1'b0, 1'b0, 1'b0);
    end

`ifdef CART_LOADER_VERIFY_EN
    // Corrupted read-back of the second byte raises the sticky error flag.
    corrupt_en = 1'b1; corrupt_a = 15'h0601;
    run_transfer(1'b0, 15'h0600, 3, 0, 1'b0, 1'b0, 1'b1);
    corrupt_en = 1'b0;
    run_transfer(1'b0, 15'h0700, 1, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
